avmm_cmd_master: RTL and testbench

- Avalon-MM host that drives the peripheral subsystem's bridge slave port: 24-bit address, 32-bit data, burstcount fixed at 1.
- Takes single-beat read and write commands on a valid/ready stream from a debug/command source.
- Issues pipelined transfers that honour waitrequest.
- Returns read data in order on a backpressurable response stream, buffered so that readdatavalid is never lost.

---
 rtl/avmm_cmd_master.sv | 110 +++++++++++
 tb/tb_avmm_cmd_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_cmd_master.sv
// avmm_cmd_master: Avalon-MM host issuing single-beat commands with credit-limited, in-order buffered read responses
module avmm_cmd_master #(
   parameter int ADDR_W          = 24,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_address,
   input  logic [DATA_W-1:0]   cmd_writedata,
   input  logic [DATA_W/8-1:0] cmd_byteenable,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_readdata,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   output logic                avm_burstcount,
   output logic                avm_debugaccess,
   input  logic                avm_waitrequest,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_readdatavalid,
   input  logic                err_clear,
   output logic                timeout_err,
   output logic                protocol_err,
   output logic                busy
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic              live, req_held, rd_done, accept, acc_rd, push, pop, tmo;
   logic [CW-1:0]     credits, outstanding, count;
   logic [PW-1:0]     wptr, rptr;
   logic [TW-1:0]     timer;
   logic [DATA_W-1:0] mem [MAX_OUTSTANDING];

   assign req_held        = avm_read | avm_write;
   assign rd_done         = avm_read & ~avm_waitrequest;
   assign cmd_ready       = live & (~req_held | ~avm_waitrequest) & (credits != '0) & ~timeout_err;
   assign accept          = cmd_valid & cmd_ready;
   assign acc_rd          = accept & ~cmd_write;
   assign push            = avm_readdatavalid & (outstanding != '0);
   assign pop             = rsp_valid & rsp_ready;
   assign tmo             = (outstanding != '0) & ~avm_readdatavalid & (timer == TW'(TIMEOUT_CYCLES - 1));
   assign rsp_valid       = count != '0;
   assign rsp_readdata    = rsp_valid ? mem[rptr] : '0;
   assign busy            = req_held | (outstanding != '0) | rsp_valid;
   assign avm_burstcount  = 1'b1;
   assign avm_debugaccess = 1'b0;

   // request register: load on accept, hold under waitrequest, drop strobes after completion
   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_address    <= '0;
         avm_writedata  <= '0;
         avm_byteenable <= '0;
      end else if (accept) begin
         avm_read       <= ~cmd_write;
         avm_write      <= cmd_write;
         avm_address    <= cmd_address;
         avm_writedata  <= cmd_writedata;
         avm_byteenable <= cmd_byteenable;
      end else if (!avm_waitrequest) begin
         avm_read  <= 1'b0;
         avm_write <= 1'b0;
      end

   // read credits, outstanding count, idle timer and sticky error flags
   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
         live         <= 1'b0;
         credits      <= CW'(MAX_OUTSTANDING);
         outstanding  <= '0;
         timer        <= '0;
         timeout_err  <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         live         <= 1'b1;
         credits      <= credits + CW'(pop) - CW'(acc_rd) + (tmo ? outstanding : '0);
         outstanding  <= tmo ? CW'(rd_done) : outstanding + CW'(rd_done) - CW'(push);
         timer        <= (tmo | avm_readdatavalid | (outstanding == '0)) ? '0 : timer + TW'(1);
         timeout_err  <= tmo | (timeout_err & ~err_clear);
         protocol_err <= (avm_readdatavalid & (outstanding == '0)) | (protocol_err & ~err_clear);
      end

   // response FIFO pointers and occupancy
   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + PW'(push);
         rptr  <= rptr + PW'(pop);
         count <= count + CW'(push) - CW'(pop);
      end

   // response FIFO storage, written by accepted readdatavalid beats
   always_ff @(posedge clk_clk)
      if (push) mem[wptr] <= avm_readdata;
endmodule

// File: tb/tb_avmm_cmd_master.sv
// tb_avmm_cmd_master: table vectors, directed corner sequences and a randomized queue-model check of avmm_cmd_master
module tb_avmm_cmd_master;
   localparam int MAXO = 4;

   logic        clk_clk, reset_reset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [23:0] cmd_address;
   logic [31:0] cmd_writedata;
   logic [3:0]  cmd_byteenable;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_readdata;
   logic [23:0] avm_address;
   logic        avm_read, avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_burstcount, avm_debugaccess, avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid, err_clear, timeout_err, protocol_err, busy;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic cv; logic cw; logic wr; logic rdv; logic rr;
      logic [23:0] ad; logic [31:0] rd;
      logic cr; logic ar; logic aw; logic rv; logic bz;
      logic [31:0] rdat;
   } vec_t;
   vec_t tv[$];

   typedef struct packed { logic w; logic [23:0] a; logic [31:0] d; logic [3:0] be; } cmd_t;

   avmm_cmd_master #(.ADDR_W(24), .DATA_W(32), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(16)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_writedata(cmd_writedata), .cmd_byteenable(cmd_byteenable),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_readdata(rsp_readdata),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_burstcount(avm_burstcount), .avm_debugaccess(avm_debugaccess),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid), .err_clear(err_clear),
      .timeout_err(timeout_err), .protocol_err(protocol_err), .busy(busy)
   );

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cmd_valid = 0; cmd_write = 0; cmd_address = '0; cmd_writedata = '0; cmd_byteenable = '0;
      rsp_ready = 0; avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0; err_clear = 0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk1({tag, ".cmd_ready"}, cmd_ready, 1'b0);
      chk1({tag, ".avm_read"}, avm_read, 1'b0);
      chk1({tag, ".avm_write"}, avm_write, 1'b0);
      chkw({tag, ".avm_address"}, 32'(avm_address), 32'h0);
      chkw({tag, ".avm_writedata"}, avm_writedata, 32'h0);
      chkw({tag, ".avm_byteenable"}, 32'(avm_byteenable), 32'h0);
      chk1({tag, ".avm_burstcount"}, avm_burstcount, 1'b1);
      chk1({tag, ".avm_debugaccess"}, avm_debugaccess, 1'b0);
      chk1({tag, ".rsp_valid"}, rsp_valid, 1'b0);
      chkw({tag, ".rsp_readdata"}, rsp_readdata, 32'h0);
      chk1({tag, ".timeout_err"}, timeout_err, 1'b0);
      chk1({tag, ".protocol_err"}, protocol_err, 1'b0);
      chk1({tag, ".busy"}, busy, 1'b0);
   endtask

   task automatic check_credits(input string tag);
      int acc, pops;
      logic pend;
      acc = 0; pops = 0; pend = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_clk);
         cmd_valid = 1; cmd_write = 0; cmd_address = 24'h80; avm_waitrequest = 0; rsp_ready = 0;
         avm_readdatavalid = pend; avm_readdata = 32'hC0 + 32'(i);
         #1;
         if (cmd_ready) acc++;
         pend = avm_read;
      end
      chkw({tag, ".credit_accepts"}, acc, 32'd4);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_clk);
         cmd_valid = 0; avm_readdatavalid = 0; rsp_ready = 1;
         #1;
         if (!rsp_valid) break;
         pops++;
      end
      chkw({tag, ".responses"}, pops, 32'd4);
      chk1({tag, ".busy_after"}, busy, 1'b0);
      rsp_ready = 0;
   endtask

   task automatic add(input logic cv, cw, wr, rdv, rr, input logic [23:0] ad, input logic [31:0] rd,
                      input logic cr, ar, aw, rv, bz, input logic [31:0] rdat);
      tv.push_back({cv, cw, wr, rdv, rr, ad, rd, cr, ar, aw, rv, bz, rdat});
   endtask

   task automatic run_random(input int n);
      cmd_t pend[$];
      cmd_t c, h;
      logic [31:0] rspq[$];
      logic [31:0] sl_d[$];
      int sl_due[$];
      int outr, last_due, credits, np, due;
      logic mrdy, hv;
      outr = 0; last_due = 0;
      for (int cyc = 0; cyc < n; cyc++) begin
         @(negedge clk_clk);
         c.w = 1'($urandom); c.a = 24'($urandom); c.d = $urandom; c.be = 4'($urandom);
         cmd_valid = (cyc < n - 40) && ($urandom_range(0, 9) < 6);
         cmd_write = c.w; cmd_address = c.a; cmd_writedata = c.d; cmd_byteenable = c.be;
         avm_waitrequest = (cyc < n - 40) && ($urandom_range(0, 9) < 3);
         rsp_ready = (cyc >= n - 40) || ($urandom_range(0, 9) < 6);
         if (sl_d.size() != 0 && sl_due[0] <= cyc) begin
            avm_readdatavalid = 1; avm_readdata = sl_d.pop_front(); void'(sl_due.pop_front());
         end else begin
            avm_readdatavalid = 0; avm_readdata = $urandom;
         end
         #1;
         np = 0;
         foreach (pend[i]) if (!pend[i].w) np++;
         credits = MAXO - outr - rspq.size() - np;
         hv = pend.size() != 0;
         mrdy = (!hv || !avm_waitrequest) && credits > 0;
         chk1("rnd.cmd_ready", cmd_ready, mrdy);
         chk1("rnd.avm_read", avm_read, hv && !pend[0].w);
         chk1("rnd.avm_write", avm_write, hv && pend[0].w);
         if (hv) begin
            chkw("rnd.avm_address", 32'(avm_address), 32'(pend[0].a));
            if (pend[0].w) begin
               chkw("rnd.avm_writedata", avm_writedata, pend[0].d);
               chkw("rnd.avm_byteenable", 32'(avm_byteenable), 32'(pend[0].be));
            end
         end
         chk1("rnd.rsp_valid", rsp_valid, rspq.size() != 0);
         if (rspq.size() != 0) chkw("rnd.rsp_readdata", rsp_readdata, rspq[0]);
         chk1("rnd.busy", busy, hv || outr != 0 || rspq.size() != 0);
         chk1("rnd.errs", timeout_err | protocol_err, 1'b0);
         if (rspq.size() != 0 && rsp_ready) void'(rspq.pop_front());
         if (avm_readdatavalid) begin
            outr--;
            rspq.push_back(avm_readdata);
         end
         if (hv && !avm_waitrequest) begin
            h = pend.pop_front();
            if (!h.w) begin
               outr++;
               due = cyc + $urandom_range(1, 3);
               last_due = (due > last_due) ? due : last_due + 1;
               sl_d.push_back($urandom);
               sl_due.push_back(last_due);
            end
         end
         if (cmd_valid && mrdy) pend.push_back(c);
      end
      chkw("rnd.drained", 32'(rspq.size() + outr + pend.size() + sl_d.size()), 32'h0);
      idle_inputs();
   endtask

   initial begin
      reset_reset_n = 0;
      idle_inputs();
      repeat (3) @(negedge clk_clk);
      #1;
      chk_reset_state("rst");
      @(negedge clk_clk);
      reset_reset_n = 1;
      repeat (2) @(negedge clk_clk);

      // write with three waitrequest cycles
      add(1,1,0,0,0, 24'h10, 0, 1,0,0,0,0, 0);
      add(0,1,1,0,0, 24'h10, 0, 0,0,1,0,1, 0);
      add(0,1,1,0,0, 24'h10, 0, 0,0,1,0,1, 0);
      add(0,1,1,0,0, 24'h10, 0, 0,0,1,0,1, 0);
      add(0,1,0,0,0, 24'h10, 0, 1,0,1,0,1, 0);
      add(0,1,0,0,0, 24'h10, 0, 1,0,0,0,0, 0);
      // credit limit with rsp_ready low, then push and pop at occupancy 2
      add(1,0,0,0,0, 24'h20, 0,        1,0,0,0,0, 0);
      add(1,0,0,0,0, 24'h20, 0,        1,1,0,0,1, 0);
      add(1,0,0,1,0, 24'h20, 32'hA1,   1,1,0,0,1, 0);
      add(1,0,0,1,0, 24'h20, 32'hA2,   1,1,0,1,1, 32'hA1);
      add(1,0,0,1,0, 24'h20, 32'hA3,   0,1,0,1,1, 32'hA1);
      add(1,0,0,1,0, 24'h20, 32'hA4,   0,0,0,1,1, 32'hA1);
      add(1,0,0,0,1, 24'h20, 0,        0,0,0,1,1, 32'hA1);
      add(1,0,0,0,0, 24'h20, 0,        1,0,0,1,1, 32'hA2);
      add(1,0,0,0,0, 24'h20, 0,        0,1,0,1,1, 32'hA2);
      add(0,0,0,0,1, 24'h20, 0,        0,0,0,1,1, 32'hA2);
      add(0,0,0,1,1, 24'h20, 32'hA5,   1,0,0,1,1, 32'hA3);
      add(0,0,0,0,1, 24'h20, 0,        1,0,0,1,1, 32'hA4);
      add(0,0,0,0,1, 24'h20, 0,        1,0,0,1,1, 32'hA5);
      add(0,0,0,0,0, 24'h20, 0,        1,0,0,0,0, 0);
      foreach (tv[i]) begin
         @(negedge clk_clk);
         cmd_valid = tv[i].cv; cmd_write = tv[i].cw; cmd_address = tv[i].ad;
         cmd_writedata = 32'hDEADBEEF; cmd_byteenable = 4'hF;
         avm_waitrequest = tv[i].wr; avm_readdatavalid = tv[i].rdv; avm_readdata = tv[i].rd;
         rsp_ready = tv[i].rr;
         #1;
         chk1($sformatf("vec%0d.cmd_ready", i), cmd_ready, tv[i].cr);
         chk1($sformatf("vec%0d.avm_read", i), avm_read, tv[i].ar);
         chk1($sformatf("vec%0d.avm_write", i), avm_write, tv[i].aw);
         chk1($sformatf("vec%0d.rsp_valid", i), rsp_valid, tv[i].rv);
         chk1($sformatf("vec%0d.busy", i), busy, tv[i].bz);
         chk1($sformatf("vec%0d.errs", i), timeout_err | protocol_err, 1'b0);
         if (tv[i].rv) chkw($sformatf("vec%0d.rsp_readdata", i), rsp_readdata, tv[i].rdat);
         if (tv[i].ar | tv[i].aw) chkw($sformatf("vec%0d.avm_address", i), 32'(avm_address), 32'(tv[i].ad));
         if (tv[i].aw) begin
            chkw($sformatf("vec%0d.avm_writedata", i), avm_writedata, 32'hDEADBEEF);
            chkw($sformatf("vec%0d.avm_byteenable", i), 32'(avm_byteenable), 32'hF);
         end
      end
      idle_inputs();

      // four back-to-back reads, slave latency 2
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk_clk);
         cmd_valid = cyc < 4; cmd_write = 0; cmd_address = 24'(32'h100 + 4 * cyc);
         avm_waitrequest = 0; rsp_ready = 1;
         avm_readdatavalid = cyc >= 3 && cyc <= 6; avm_readdata = 32'h11 * 32'(cyc - 2);
         #1;
         if (cyc < 4) chk1("b2b.cmd_ready", cmd_ready, 1'b1);
         chk1("b2b.avm_read", avm_read, cyc >= 1 && cyc <= 4);
         if (cyc >= 1 && cyc <= 4) chkw("b2b.avm_address", 32'(avm_address), 32'h100 + 32'(4 * (cyc - 1)));
         chk1("b2b.rsp_valid", rsp_valid, cyc >= 4 && cyc <= 7);
         if (cyc >= 4 && cyc <= 7) chkw("b2b.rsp_readdata", rsp_readdata, 32'h11 * 32'(cyc - 3));
         if (cyc == 11) chk1("b2b.busy_end", busy, 1'b0);
      end
      idle_inputs();

      // read never answered: timeout, late data, error clear
      for (int cyc = 0; cyc < 23; cyc++) begin
         @(negedge clk_clk);
         cmd_valid = (cyc == 0) || (cyc >= 18 && cyc <= 20); cmd_write = 0; cmd_address = 24'h40;
         avm_waitrequest = 0; rsp_ready = 0; avm_readdatavalid = cyc == 19; avm_readdata = 32'hBAD;
         err_clear = cyc == 21;
         #1;
         if (cyc == 1) chk1("tmo.avm_read", avm_read, 1'b1);
         if (cyc == 17) chk1("tmo.not_yet", timeout_err, 1'b0);
         if (cyc == 18) begin
            chk1("tmo.timeout_err", timeout_err, 1'b1);
            chk1("tmo.cmd_ready", cmd_ready, 1'b0);
            chk1("tmo.busy", busy, 1'b0);
         end
         if (cyc == 19) begin
            chk1("tmo.no_issue", avm_read, 1'b0);
            chk1("tmo.perr_before", protocol_err, 1'b0);
         end
         if (cyc == 20) begin
            chk1("tmo.protocol_err", protocol_err, 1'b1);
            chk1("tmo.dropped", rsp_valid, 1'b0);
         end
         if (cyc == 21) chk1("tmo.still_set", timeout_err, 1'b1);
         if (cyc == 22) begin
            chk1("tmo.cleared_t", timeout_err, 1'b0);
            chk1("tmo.cleared_p", protocol_err, 1'b0);
            chk1("tmo.ready_again", cmd_ready, 1'b1);
         end
      end
      idle_inputs();
      check_credits("tmo");

      run_random(2500);

      // reset asserted with a read stalled on the bus and two reads outstanding
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk_clk);
         cmd_valid = cyc < 3; cmd_write = 0; cmd_address = 24'h60;
         avm_waitrequest = cyc == 3; rsp_ready = 0; avm_readdatavalid = 0;
         #1;
      end
      chk1("rst_mid.setup_read", avm_read, 1'b1);
      chk1("rst_mid.setup_busy", busy, 1'b1);
      reset_reset_n = 0;
      #1;
      chk_reset_state("rst_mid");
      idle_inputs();
      repeat (2) @(negedge clk_clk);
      reset_reset_n = 1;
      repeat (2) @(negedge clk_clk);
      #1;
      chk1("rst_mid.fifo_empty", rsp_valid, 1'b0);
      check_credits("rst_mid");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
